// File: rtl/dec_fwd_stage.sv
// dec_fwd_stage: single-entry decode/operand stage with prioritised
// operand forwarding, load-use interlock and early branch resolution.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_*                 upstream valid/ready handshake and decoded fields
//   rf_idx*/rf_val*      register file read index out, data in
//   fwd_dst/val/rdy      NFWD producer slices, slice 0 youngest
//   flush                kill the held instruction
//   out_*                downstream handshake, held fields, operands
//   br_taken/br_target   redirect (qualified by out_valid & out_ready)
//   hazard_cnt           saturating count of interlocked cycles
module dec_fwd_stage #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int NFWD   = 3,
    parameter bit BR_EN  = 1'b1,
    parameter int HCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [RIDX_W-1:0]      in_src1,
    input  logic [RIDX_W-1:0]      in_src2,
    input  logic [RIDX_W-1:0]      in_dst,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [2:0]             in_brop,
    output logic [RIDX_W-1:0]      rf_idx1,
    output logic [RIDX_W-1:0]      rf_idx2,
    input  logic [XLEN-1:0]        rf_val1,
    input  logic [XLEN-1:0]        rf_val2,
    input  logic [NFWD*RIDX_W-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0]   fwd_val,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_imm,
    output logic [RIDX_W-1:0]      out_dst,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic                   br_taken,
    output logic [XLEN-1:0]        br_target,
    output logic [HCNT_W-1:0]      hazard_cnt
);

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [HCNT_W-1:0] HCNT_ONE = 1;
    localparam logic [XLEN-1:0]   PC_STEP  = 4;

    logic              v_q, v_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [RIDX_W-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [2:0]        brop_q, brop_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;

    logic [XLEN:0]     res1, res2;
    logic              hazard, in_fire, out_fire, cond;
    logic [XLEN-1:0]   tgt;

    // Returns {ready, value}; the lowest matching slice wins and a
    // zero destination never matches because s is nonzero there.
    function automatic logic [XLEN:0] resolve(
        input logic [RIDX_W-1:0]      s,
        input logic [XLEN-1:0]        rf,
        input logic [NFWD*RIDX_W-1:0] fd,
        input logic [NFWD*XLEN-1:0]   fv,
        input logic [NFWD-1:0]        fr
    );
        logic [XLEN:0] r;
        logic          hit;
        r   = {1'b1, rf};
        hit = 1'b0;
        if (s == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end else begin
            for (int i = 0; i < NFWD; i++) begin
                if (!hit && fd[i*RIDX_W +: RIDX_W] == s) begin
                    hit = 1'b1;
                    r   = {fr[i], fv[i*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    assign res1 = resolve(src1_q, rf_val1, fwd_dst, fwd_val, fwd_rdy);
    assign res2 = resolve(src2_q, rf_val2, fwd_dst, fwd_val, fwd_rdy);

    assign out_op1 = res1[XLEN-1:0];
    assign out_op2 = res2[XLEN-1:0];

    // Source 0 resolves ready, so only real pending producers stall.
    assign hazard    = v_q & ~(res1[XLEN] & res2[XLEN]);
    assign out_valid = v_q & ~hazard & ~flush;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = ~v_q | out_fire;
    assign in_fire   = in_valid & in_ready;

    assign rf_idx1    = src1_q;
    assign rf_idx2    = src2_q;
    assign out_pc     = pc_q;
    assign out_imm    = imm_q;
    assign out_dst    = dst_q;
    assign hazard_cnt = hcnt_q;

    // Signed compares against zero reduce to sign bit and zero test.
    always_comb begin
        cond = 1'b0;
        case (brop_q)
            3'd1:    cond = out_op1 == out_op2;
            3'd2:    cond = out_op1 != out_op2;
            3'd3:    cond = out_op1[XLEN-1] | (out_op1 == '0);
            3'd4:    cond = ~out_op1[XLEN-1] & (out_op1 != '0);
            3'd5:    cond = out_op1[XLEN-1];
            3'd6:    cond = ~out_op1[XLEN-1];
            3'd7:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign tgt = (brop_q == 3'd7) ? out_op1
               : pc_q + PC_STEP + (imm_q << 2);

    if (BR_EN) begin : g_br
        assign br_taken  = out_valid & cond;
        assign br_target = tgt;
    end else begin : g_nobr
        assign br_taken  = 1'b0;
        assign br_target = '0;
    end

    always_comb begin
        v_d    = v_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        src1_d = src1_q;
        src2_d = src2_q;
        dst_d  = dst_q;
        brop_d = brop_q;
        hcnt_d = hcnt_q;
        if (hazard && hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + HCNT_ONE;
        end
        if (flush) begin
            v_d = 1'b0;
        end else if (in_fire) begin
            v_d    = 1'b1;
            pc_d   = in_pc;
            imm_d  = in_imm;
            src1_d = in_src1;
            src2_d = in_src2;
            dst_d  = in_dst;
            brop_d = in_brop;
        end else if (out_fire) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            imm_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            brop_q <= '0;
            hcnt_q <= '0;
        end else begin
            v_q    <= v_d;
            pc_q   <= pc_d;
            imm_q  <= imm_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            dst_q  <= dst_d;
            brop_q <= brop_d;
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: tb/tb_dec_fwd_stage.sv
// tb_dec_fwd_stage: directed and randomized checks of dec_fwd_stage
// against a cycle-level behavioural model of the stage.
module tb_dec_fwd_stage;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;
    localparam int NFWD   = 3;
    localparam int HCNT_W = 4;

    logic                   clk, resetn;
    logic                   in_valid, in_ready;
    logic [XLEN-1:0]        in_pc, in_imm;
    logic [RIDX_W-1:0]      in_src1, in_src2, in_dst;
    logic [2:0]             in_brop;
    logic [RIDX_W-1:0]      rf_idx1, rf_idx2;
    logic [XLEN-1:0]        rf_val1, rf_val2;
    logic [NFWD*RIDX_W-1:0] fwd_dst;
    logic [NFWD*XLEN-1:0]   fwd_val;
    logic [NFWD-1:0]        fwd_rdy;
    logic                   flush, out_valid, out_ready;
    logic [XLEN-1:0]        out_pc, out_imm, out_op1, out_op2;
    logic [RIDX_W-1:0]      out_dst;
    logic                   br_taken;
    logic [XLEN-1:0]        br_target;
    logic [HCNT_W-1:0]      hazard_cnt;

    logic [4:0]  fd[NFWD];
    logic [31:0] fv[NFWD];
    logic        fr[NFWD];
    logic [31:0] regs[32];

    // model of the held instruction
    bit          m_v;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_src1, m_src2, m_dst;
    logic [2:0]  m_brop;
    int          m_cnt;

    int vec = 0;
    int errs = 0;

    dec_fwd_stage #(
        .XLEN(XLEN), .RIDX_W(RIDX_W), .NFWD(NFWD),
        .BR_EN(1'b1), .HCNT_W(HCNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst(in_dst), .in_imm(in_imm), .in_brop(in_brop),
        .rf_idx1(rf_idx1), .rf_idx2(rf_idx2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .fwd_dst(fwd_dst), .fwd_val(fwd_val), .fwd_rdy(fwd_rdy),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_dst(out_dst),
        .out_op1(out_op1), .out_op2(out_op2),
        .br_taken(br_taken), .br_target(br_target),
        .hazard_cnt(hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fwd_dst = '0;
        fwd_val = '0;
        fwd_rdy = '0;
        for (int i = 0; i < NFWD; i++) begin
            fwd_dst[i*RIDX_W +: RIDX_W] = fd[i];
            fwd_val[i*XLEN +: XLEN]     = fv[i];
            fwd_rdy[i]                  = fr[i];
        end
    end

    assign rf_val1 = regs[rf_idx1];
    assign rf_val2 = regs[rf_idx2];

    function automatic logic [31:0] ref_op(input logic [4:0] s,
                                           output bit rdy);
        logic [31:0] v;
        bit hit;
        rdy = 1;
        hit = 0;
        v = regs[s];
        if (s == 0) v = 0;
        else
            for (int i = 0; i < NFWD; i++)
                if (!hit && fd[i] == s) begin
                    hit = 1;
                    v = fv[i];
                    rdy = fr[i];
                end
        return v;
    endfunction

    function automatic bit ref_hazard();
        bit r1, r2;
        logic [31:0] d;
        d = ref_op(m_src1, r1);
        d = ref_op(m_src2, r2);
        return m_v && !(r1 && r2);
    endfunction

    function automatic bit ref_valid();
        return m_v && !ref_hazard() && !flush;
    endfunction

    function automatic bit ref_ready();
        return !m_v || (ref_valid() && out_ready);
    endfunction

    function automatic bit ref_taken();
        bit r;
        logic [31:0] a, b;
        int sa;
        a = ref_op(m_src1, r);
        b = ref_op(m_src2, r);
        sa = int'(a);
        if (!ref_valid()) return 0;
        case (m_brop)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return sa <= 0;
            3'd4: return sa > 0;
            3'd5: return sa < 0;
            3'd6: return sa >= 0;
            3'd7: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target();
        bit r;
        logic [31:0] a;
        a = ref_op(m_src1, r);
        if (m_brop == 3'd7) return a;
        return m_pc + 32'd4 + m_imm * 32'd4;
    endfunction

    // advance one clock, updating the model from pre-edge inputs
    task automatic tick();
        bit hz, ld, of;
        hz = ref_hazard();
        ld = in_valid && ref_ready();
        of = ref_valid() && out_ready;
        @(posedge clk);
        if (!resetn) begin
            m_v = 0; m_pc = 0; m_imm = 0; m_src1 = 0;
            m_src2 = 0; m_dst = 0; m_brop = 0; m_cnt = 0;
        end else begin
            if (hz && m_cnt < 15) m_cnt++;
            if (flush) m_v = 0;
            else if (ld) begin
                m_v = 1; m_pc = in_pc; m_imm = in_imm;
                m_src1 = in_src1; m_src2 = in_src2;
                m_dst = in_dst; m_brop = in_brop;
            end else if (of) m_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NFWD; i++) begin
            fd[i] = 0; fv[i] = $urandom; fr[i] = 0;
        end
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [2:0] bo);
        clear_fwd();
        flush = 0; out_ready = 1; in_valid = 1;
        in_pc = pc; in_imm = imm; in_src1 = s1; in_src2 = s2;
        in_dst = d; in_brop = bo;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        resetn = 0; in_valid = 1; in_pc = 32'h1234;
        tick();
        resetn = 1; in_valid = 0;
        #2;
        vec++; if (out_valid !== 1'b0) begin errs++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vec++; if (in_ready !== 1'b1) begin errs++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vec++; if (br_taken !== 1'b0) begin errs++;
            $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
        vec++; if (hazard_cnt !== 4'd0 || out_pc !== 32'd0 ||
                   out_dst !== 5'd0) begin errs++;
            $display("FAIL reset_fields got cnt=%h pc=%h dst=%h exp=0",
                     hazard_cnt, out_pc, out_dst); end
    endtask

    task automatic test_back_to_back();
        regs[3] = 32'd7;
        clear_fwd();
        out_ready = 1; flush = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 4); in_pc = 32'h100 + 32'(4 * k);
            in_src1 = 3; in_src2 = 0; in_dst = 5'(k + 1);
            in_imm = 0; in_brop = 0;
            #2;
            vec++; if (in_ready !== 1'b1) begin errs++;
                $display("FAIL b2b_in_ready k=%0d got=%b exp=1",
                         k, in_ready); end
            if (k > 0) begin
                vec++; if (out_valid !== 1'b1) begin errs++;
                    $display("FAIL b2b_out_valid k=%0d got=%b exp=1",
                             k, out_valid); end
                vec++; if (out_op1 !== 32'd7 || out_op2 !== 32'd0) begin
                    errs++;
                    $display("FAIL b2b_ops got=%h/%h exp=7/0",
                             out_op1, out_op2); end
                vec++; if (out_pc !== 32'h100 + 32'(4 * (k - 1))) begin
                    errs++;
                    $display("FAIL b2b_pc got=%h exp=%h", out_pc,
                             32'h100 + 32'(4 * (k - 1))); end
            end
            tick();
        end
    endtask

    task automatic test_fwd_priority();
        load(32'h180, 0, 5, 0, 2, 0);
        out_ready = 0;
        fd[0] = 5; fv[0] = 32'hAA; fr[0] = 1;
        fd[1] = 5; fv[1] = 32'hBB; fr[1] = 1;
        fd[2] = 0; fv[2] = 32'hCC; fr[2] = 0;
        #2;
        vec++; if (out_valid !== 1'b1 || out_op1 !== 32'hAA) begin errs++;
            $display("FAIL fwd_youngest got v=%b op1=%h exp v=1 op1=aa",
                     out_valid, out_op1); end
        fd[0] = 0;
        #2;
        vec++; if (out_op1 !== 32'hBB) begin errs++;
            $display("FAIL fwd_second got=%h exp=bb", out_op1); end
        fd[1] = 0;
        #2;
        vec++; if (out_op1 !== regs[5]) begin errs++;
            $display("FAIL fwd_rf got=%h exp=%h", out_op1, regs[5]); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_load_use();
        int c0;
        load(32'h280, 0, 0, 4, 3, 0);
        c0 = m_cnt;
        fd[0] = 4; fr[0] = 0; fv[0] = 32'hDEAD;
        in_valid = 1; in_pc = 32'h300; in_src1 = 0; in_src2 = 0;
        in_brop = 0; out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #2;
            vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL lu_stall k=%0d got v=%b rdy=%b exp 0/0",
                         k, out_valid, in_ready); end
            tick();
        end
        #2;
        vec++; if (hazard_cnt !== 4'(c0 + 3)) begin errs++;
            $display("FAIL lu_cnt got=%0d exp=%0d", hazard_cnt, c0 + 3); end
        fr[0] = 1; fv[0] = 32'h55;
        #1;
        vec++; if (out_valid !== 1'b1 || out_op2 !== 32'h55 ||
                   in_ready !== 1'b1) begin errs++;
            $display("FAIL lu_release got v=%b op2=%h rdy=%b exp 1/55/1",
                     out_valid, out_op2, in_ready); end
        tick();
        in_valid = 0; clear_fwd();
        #2;
        vec++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin errs++;
            $display("FAIL lu_next got v=%b pc=%h exp 1/300",
                     out_valid, out_pc); end
        tick();
    endtask

    task automatic test_branch();
        logic [31:0] pc, imm, et;
        logic [2:0] bo;
        bit ex;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin regs[1] = 9; regs[2] = 9; pc = 32'h200;
                   imm = 32'hFFFF_FFFE; bo = 1; ex = 1; et = 32'h1FC; end
                1: begin regs[1] = 32'h8000_0000; pc = 32'h240;
                   imm = 3; bo = 6; ex = 0; et = 0; end
                default: begin regs[1] = 32'h400; pc = 32'h260;
                   imm = 5; bo = 7; ex = 1; et = 32'h400; end
            endcase
            load(pc, imm, 1, (k == 0) ? 5'd2 : 5'd0, 9, bo);
            #2;
            vec++; if (br_taken !== ex) begin errs++;
                $display("FAIL br_taken k=%0d got=%b exp=%b",
                         k, br_taken, ex); end
            if (k != 1) begin
                vec++; if (br_target !== et) begin errs++;
                    $display("FAIL br_target k=%0d got=%h exp=%h",
                             k, br_target, et); end
            end
            tick();
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] v;
        v = $urandom;
        regs[3] = v;
        load(32'h500, 0, 3, 0, 7, 0);
        out_ready = 0; in_valid = 1; in_pc = 32'h999; in_src1 = 0;
        for (int k = 0; k < 2; k++) begin
            #2;
            vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL stall_hs got v=%b rdy=%b exp 1/0",
                         out_valid, in_ready); end
            vec++; if (out_pc !== 32'h500 || out_op1 !== v ||
                       out_dst !== 5'd7) begin errs++;
                $display("FAIL stall_hold got pc=%h op1=%h dst=%h",
                         out_pc, out_op1, out_dst); end
            tick();
        end
        flush = 1;
        #2;
        vec++; if (out_valid !== 1'b0) begin errs++;
            $display("FAIL flush_kill got=%b exp=0", out_valid); end
        tick();
        #2;
        vec++; if (in_ready !== 1'b1) begin errs++;
            $display("FAIL flush_rdy got=%b exp=1", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        #2;
        vec++; if (out_valid !== 1'b0) begin errs++;
            $display("FAIL flush_noload got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        bit ev;
        for (int r = 0; r < 8; r++)
            regs[r] = 32'($urandom_range(0, 3)) - 32'd1;
        for (int n = 0; n < 400; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_pc = $urandom; in_imm = $urandom;
            in_src1 = 5'($urandom_range(0, 7));
            in_src2 = 5'($urandom_range(0, 7));
            in_dst = 5'($urandom_range(0, 31));
            in_brop = 3'($urandom_range(0, 7));
            for (int i = 0; i < NFWD; i++) begin
                fd[i] = 5'($urandom_range(0, 7));
                fv[i] = 32'($urandom_range(0, 4)) - 32'd2;
                fr[i] = $urandom_range(0, 4) != 0;
            end
            #2;
            ev = ref_valid();
            vec++; if (out_valid !== ev || in_ready !== ref_ready()) begin
                errs++;
                $display("FAIL rnd_hs n=%0d got v=%b rdy=%b exp %b/%b",
                         n, out_valid, in_ready, ev, ref_ready()); end
            vec++; if (hazard_cnt !== 4'(m_cnt) || rf_idx1 !== m_src1 ||
                       rf_idx2 !== m_src2) begin errs++;
                $display("FAIL rnd_state n=%0d got cnt=%0d idx=%0d/%0d",
                         n, hazard_cnt, rf_idx1, rf_idx2); end
            vec++; if (br_taken !== ref_taken()) begin errs++;
                $display("FAIL rnd_br n=%0d got=%b exp=%b",
                         n, br_taken, ref_taken()); end
            if (ev) begin
                bit r;
                logic [31:0] e1, e2;
                e1 = ref_op(m_src1, r);
                e2 = ref_op(m_src2, r);
                vec++; if (out_op1 !== e1 || out_op2 !== e2) begin errs++;
                    $display("FAIL rnd_ops n=%0d got %h/%h exp %h/%h",
                             n, out_op1, out_op2, e1, e2); end
                vec++; if (out_pc !== m_pc || out_dst !== m_dst ||
                           br_target !== ref_target()) begin errs++;
                    $display("FAIL rnd_fields n=%0d pc=%h tgt=%h exp %h/%h",
                             n, out_pc, br_target, m_pc, ref_target()); end
            end
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        clear_fwd();
        tick();
        tick();
    endtask

    task automatic test_saturate();
        resetn = 0;
        tick();
        resetn = 1;
        load(32'h600, 0, 6, 0, 1, 0);
        fd[1] = 6; fr[1] = 0;
        repeat (21) tick();
        #2;
        vec++; if (hazard_cnt !== 4'hF) begin errs++;
            $display("FAIL sat_cnt got=%0d exp=15", hazard_cnt); end
        vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errs++;
            $display("FAIL sat_hs got v=%b rdy=%b exp 0/0",
                     out_valid, in_ready); end
        resetn = 0;
        tick();
        resetn = 1;
        #2;
        vec++; if (out_valid !== 1'b0 || hazard_cnt !== 4'd0 ||
                   in_ready !== 1'b1) begin errs++;
            $display("FAIL sat_reset got v=%b cnt=%0d rdy=%b exp 0/0/1",
                     out_valid, hazard_cnt, in_ready); end
    endtask

    initial begin
        resetn = 0; in_valid = 0; flush = 0; out_ready = 1;
        in_pc = 0; in_imm = 0; in_src1 = 0; in_src2 = 0;
        in_dst = 0; in_brop = 0;
        m_v = 0; m_pc = 0; m_imm = 0; m_src1 = 0; m_src2 = 0;
        m_dst = 0; m_brop = 0; m_cnt = 0;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        clear_fwd();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_fwd_priority();
        test_load_use();
        test_branch();
        test_stall_flush();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
